serial_subtractor: RTL and testbench

Bit-serial unsigned subtractor; the inverse operation of the team's combinational full-adder datapath. It computes diff = a - b one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow flip-flop. A start/busy/done handshake lets a controller launch one operation at a time and collect a stable result.

---
 rtl/serial_subtractor.sv | 113 +++++++++++
 tb/tb_serial_subtractor.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first.
// One full-subtractor cell plus a borrow flop; start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out,
    output logic             busy_out,
    output logic             done_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CW-1:0]    cnt;
    logic             bor;

    logic a_bit;
    logic b_bit;
    logic d_bit;
    logic bor_nxt;
    logic last_bit;

    always_comb begin
        a_bit    = a_sr[0];
        b_bit    = b_sr[0];
        d_bit    = a_bit ^ b_bit ^ bor;
        bor_nxt  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bor);
        last_bit = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy_out  = 1'b0;
        done_out  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_in) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy_out = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_out  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Result fills from the top so bit i settles at position i after WIDTH steps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            cnt        <= '0;
            bor        <= 1'b0;
            diff_out   <= '0;
            borrow_out <= 1'b0;
        end else begin
            if (state == IDLE && start_in) begin
                a_sr <= a_in;
                b_sr <= b_in;
                bor  <= 1'b0;
                cnt  <= '0;
            end else if (state == SHIFT) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                res_sr <= {d_bit, res_sr[WIDTH-1:1]};
                bor    <= bor_nxt;
                if (last_bit) begin
                    diff_out   <= {d_bit, res_sr[WIDTH-1:1]};
                    borrow_out <= bor_nxt;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8).
// Expected results are queued at accept and compared when done_out pulses.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] diff_out;
    logic             borrow_out;
    logic             busy_out;
    logic             done_out;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_in   (start_in),
        .a_in       (a_in),
        .b_in       (b_in),
        .diff_out   (diff_out),
        .borrow_out (borrow_out),
        .busy_out   (busy_out),
        .done_out   (done_out)
    );

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] diff;
        logic             bor;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             bor;
        int               due;
    } exp_t;

    exp_t q[$];
    exp_t e;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [WIDTH-1:0] last_diff = '0;
    logic             last_bor  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    // Scoreboard side: compare on done, and check result stability otherwise.
    always @(negedge clk) begin
        if (rst) begin
            last_diff = '0;
            last_bor  = 1'b0;
        end else begin
            chk("busy_done_excl", 32'(busy_out & done_out), 32'd0);
            if (done_out) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done with empty queue at cycle %0d", cyc);
                end else begin
                    e = q.pop_front();
                    chk("diff", 32'(diff_out), 32'(e.diff));
                    chk("borrow", 32'(borrow_out), 32'(e.bor));
                    chk("done_latency", 32'(cyc), 32'(e.due));
                end
                last_diff = diff_out;
                last_bor  = borrow_out;
            end else begin
                chk("diff_stable", 32'(diff_out), 32'(last_diff));
                chk("borrow_stable", 32'(borrow_out), 32'(last_bor));
            end
        end
    end

    task automatic wait_done(output int busy_n);
        bit seen;
        seen   = 1'b0;
        busy_n = 0;
        for (int i = 0; i < 3 * WIDTH && !seen; i++) begin
            @(negedge clk);
            if (done_out) seen = 1'b1;
            else if (busy_out) busy_n++;
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic accept_push(input logic [WIDTH-1:0] ed, input logic eb);
        exp_t x;
        @(posedge clk);
        #1;
        x.diff = ed;
        x.bor  = eb;
        x.due  = cyc + WIDTH;
        q.push_back(x);
    endtask

    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] ed, input logic eb);
        int bn;
        @(negedge clk);
        a_in     = a;
        b_in     = b;
        start_in = 1'b1;
        accept_push(ed, eb);
        start_in = 1'b0;
        wait_done(bn);
        chk("busy_cycles", 32'(bn), 32'(WIDTH));
    endtask

    vec_t vecs[8];

    initial begin
        int bn;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        vecs[0] = '{8'd100, 8'd37,  8'd63,  1'b0};
        vecs[1] = '{8'd37,  8'd100, 8'hC1,  1'b1};
        vecs[2] = '{8'h00,  8'h01,  8'hFF,  1'b1};
        vecs[3] = '{8'h5A,  8'h5A,  8'h00,  1'b0};
        vecs[4] = '{8'hFF,  8'h00,  8'hFF,  1'b0};
        vecs[5] = '{8'h00,  8'hFF,  8'h01,  1'b1};
        vecs[6] = '{8'h80,  8'h7F,  8'h01,  1'b0};
        vecs[7] = '{8'h7F,  8'h80,  8'hFF,  1'b1};

        rst      = 1'b1;
        start_in = 1'b0;
        a_in     = '0;
        b_in     = '0;
        repeat (2) @(negedge clk);
        chk("rst_diff", 32'(diff_out), 32'd0);
        chk("rst_borrow", 32'(borrow_out), 32'd0);
        chk("rst_busy", 32'(busy_out), 32'd0);
        chk("rst_done", 32'(done_out), 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy_out), 32'd0);

        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].bor);
        end

        // start held high: accepts every WIDTH+2 cycles, operand glitches ignored
        @(negedge clk);
        a_in     = 8'd10;
        b_in     = 8'd3;
        start_in = 1'b1;
        for (int o = 0; o < 3; o++) begin
            if (o == 0) begin
                accept_push(8'd7, 1'b0);
            end else begin
                @(posedge clk);
                accept_push(8'd7, 1'b0);
            end
            fork
                begin
                    repeat (3) @(negedge clk);
                    a_in = 8'hEE;
                    b_in = 8'h77;
                    repeat (2) @(negedge clk);
                    a_in = 8'd10;
                    b_in = 8'd3;
                end
            join_none
            wait_done(bn);
            chk("held_busy_cycles", 32'(bn), 32'(WIDTH));
        end
        start_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_no_requeue", 32'(busy_out), 32'd0);

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        a_in     = 8'd200;
        b_in     = 8'd50;
        start_in = 1'b1;
        @(posedge clk);
        #1 start_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_busy", 32'(busy_out), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("abort_diff", 32'(diff_out), 32'd0);
        chk("abort_borrow", 32'(borrow_out), 32'd0);
        chk("abort_busy", 32'(busy_out), 32'd0);
        chk("abort_done", 32'(done_out), 32'd0);
        q.delete();
        @(negedge clk);
        #1 rst = 1'b0;
        do_op(8'd9, 8'd4, 8'd5, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            ra = WIDTH'($urandom_range(0, 255));
            rb = WIDTH'($urandom_range(0, 255));
            do_op(ra, rb, ra - rb, ra < rb);
        end

        repeat (2) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
